// File: rtl/fft_pkg.sv
// Shared constants and types for the radix-2 butterfly combiner (Q11.5 samples).
package fft_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int FRAC_BITS  = 5;

    // Bit growth of W*Y (ac-bd, ad+bc) and of X +/- WY before saturation.
    localparam int WY_GROWTH  = 1;
    localparam int SUM_GROWTH = 2;

    localparam logic signed [DATA_WIDTH-1:0] Q_MAX = 16'sh7FFF;
    localparam logic signed [DATA_WIDTH-1:0] Q_MIN = 16'sh8000;

    typedef struct packed {
        logic signed [DATA_WIDTH-1:0] re;
        logic signed [DATA_WIDTH-1:0] im;
    } sample_t;

endpackage

// File: rtl/fft_sat_add_sub.sv
// One butterfly leg: X +/- WY at full width, optional floor halving, then
// saturation back to the data width.
module fft_sat_add_sub #(
    parameter int DATA_WIDTH = 16
) (
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH:0]   b,
    input  logic                         sub,
    input  logic                         scale,
    output logic signed [DATA_WIDTH-1:0] y,
    output logic                         sat
);
    import fft_pkg::*;

    localparam int SW = DATA_WIDTH + SUM_GROWTH;
    localparam logic signed [SW-1:0] HI = SW'({1'b0, {(DATA_WIDTH-1){1'b1}}});
    localparam logic signed [SW-1:0] LO = ~HI;

    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] shifted;

    always_comb begin
        sum     = '0;
        shifted = '0;
        y       = '0;
        sat     = 1'b0;
        sum     = sub ? (SW'(a) - SW'(b)) : (SW'(a) + SW'(b));
        // Arithmetic shift rounds toward minus infinity.
        shifted = scale ? (sum >>> 1) : sum;
        if (shifted > HI) begin
            y   = HI[DATA_WIDTH-1:0];
            sat = 1'b1;
        end else if (shifted < LO) begin
            y   = LO[DATA_WIDTH-1:0];
            sat = 1'b1;
        end else begin
            y = shifted[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/fft_butterfly_combiner.sv
// Radix-2 butterfly back end: aligns X with externally computed products of
// W*Y and produces X+WY / X-WY through two register stages.
module fft_butterfly_combiner #(
    parameter int DATA_WIDTH   = 16,
    parameter int MULT_LATENCY = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic signed [DATA_WIDTH-1:0] x_re,
    input  logic signed [DATA_WIDTH-1:0] x_im,
    input  logic                         scale,
    input  logic signed [DATA_WIDTH-1:0] prod_ac,
    input  logic signed [DATA_WIDTH-1:0] prod_bd,
    input  logic signed [DATA_WIDTH-1:0] prod_ad,
    input  logic signed [DATA_WIDTH-1:0] prod_bc,
    input  logic                         prod_valid,
    input  logic                         clear_flags,
    output logic                         done,
    output logic signed [DATA_WIDTH-1:0] upper_re,
    output logic signed [DATA_WIDTH-1:0] upper_im,
    output logic signed [DATA_WIDTH-1:0] lower_re,
    output logic signed [DATA_WIDTH-1:0] lower_im,
    output logic                         overflow,
    output logic                         align_error
);
    import fft_pkg::*;

    // enable, prod_valid and done are single-cycle qualifiers with no
    // backpressure: the block accepts every cycle and done is a one-cycle strobe.

    localparam int WY_W = DATA_WIDTH + WY_GROWTH;

    typedef struct packed {
        logic                         valid;
        logic                         scale;
        logic signed [DATA_WIDTH-1:0] re;
        logic signed [DATA_WIDTH-1:0] im;
    } dl_t;

    dl_t dl [MULT_LATENCY];
    dl_t tail;

    logic                         s1_valid;
    logic                         s1_scale;
    logic signed [DATA_WIDTH-1:0] s1_x_re;
    logic signed [DATA_WIDTH-1:0] s1_x_im;
    logic signed [WY_W-1:0]       s1_wy_re;
    logic signed [WY_W-1:0]       s1_wy_im;

    logic signed [WY_W-1:0]       wy_re_c;
    logic signed [WY_W-1:0]       wy_im_c;
    logic                         capture;
    logic                         misalign;

    logic signed [DATA_WIDTH-1:0] ure_c, uim_c, lre_c, lim_c;
    logic                         ure_sat, uim_sat, lre_sat, lim_sat;
    logic                         sat_any;

    assign tail     = dl[MULT_LATENCY-1];
    assign capture  = prod_valid & tail.valid;
    assign misalign = prod_valid ^ tail.valid;
    assign wy_re_c  = WY_W'(prod_ac) - WY_W'(prod_bd);
    assign wy_im_c  = WY_W'(prod_ad) + WY_W'(prod_bc);
    assign sat_any  = s1_valid & (ure_sat | uim_sat | lre_sat | lim_sat);

    // X and its control bits ride alongside the multipliers so they arrive
    // in the same cycle as the matching products.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MULT_LATENCY; i++) begin
                dl[i] <= '0;
            end
        end else begin
            dl[0] <= '{valid: enable, scale: scale, re: x_re, im: x_im};
            for (int i = 1; i < MULT_LATENCY; i++) begin
                dl[i] <= dl[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_scale <= 1'b0;
            s1_x_re  <= '0;
            s1_x_im  <= '0;
            s1_wy_re <= '0;
            s1_wy_im <= '0;
        end else begin
            s1_valid <= capture;
            if (capture) begin
                s1_scale <= tail.scale;
                s1_x_re  <= tail.re;
                s1_x_im  <= tail.im;
                s1_wy_re <= wy_re_c;
                s1_wy_im <= wy_im_c;
            end
        end
    end

    fft_sat_add_sub #(.DATA_WIDTH(DATA_WIDTH)) u_upper_re (
        .a(s1_x_re), .b(s1_wy_re), .sub(1'b0), .scale(s1_scale), .y(ure_c), .sat(ure_sat)
    );
    fft_sat_add_sub #(.DATA_WIDTH(DATA_WIDTH)) u_upper_im (
        .a(s1_x_im), .b(s1_wy_im), .sub(1'b0), .scale(s1_scale), .y(uim_c), .sat(uim_sat)
    );
    fft_sat_add_sub #(.DATA_WIDTH(DATA_WIDTH)) u_lower_re (
        .a(s1_x_re), .b(s1_wy_re), .sub(1'b1), .scale(s1_scale), .y(lre_c), .sat(lre_sat)
    );
    fft_sat_add_sub #(.DATA_WIDTH(DATA_WIDTH)) u_lower_im (
        .a(s1_x_im), .b(s1_wy_im), .sub(1'b1), .scale(s1_scale), .y(lim_c), .sat(lim_sat)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done     <= 1'b0;
            upper_re <= '0;
            upper_im <= '0;
            lower_re <= '0;
            lower_im <= '0;
        end else begin
            done <= s1_valid;
            if (s1_valid) begin
                upper_re <= ure_c;
                upper_im <= uim_c;
                lower_re <= lre_c;
                lower_im <= lim_c;
            end
        end
    end

    // Sticky flags: a set event in the same cycle as clear_flags wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow    <= 1'b0;
            align_error <= 1'b0;
        end else begin
            overflow    <= sat_any  | (overflow    & ~clear_flags);
            align_error <= misalign | (align_error & ~clear_flags);
        end
    end

endmodule

// File: doc/fft_butterfly_combiner.md
FFT_BUTTERFLY_COMBINER -- requirements
Module: fft_butterfly_combiner

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning signed width of every data port (Q11.5 samples, 5 fractional bits).
REQ-002 SHALL have parameter MULT_LATENCY, default 2, meaning clk cycles from fixed_point_multiplier enable to its done.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising edge active.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port enable, input, 1 bit: asserted in the same cycle the four multipliers are enabled.
REQ-006 SHALL have ports x_re and x_im, input, DATA_WIDTH each: butterfly top operand X, sampled with enable.
REQ-007 SHALL have port scale, input, 1 bit: halve both outputs of this butterfly; sampled with enable.
REQ-008 SHALL have ports prod_ac, prod_bd, prod_ad and prod_bc, input, DATA_WIDTH each: the real products of W=(a,b) and Y=(c,d).
REQ-009 SHALL have port prod_valid, input, 1 bit: the multipliers' done.
REQ-010 SHALL have port clear_flags, input, 1 bit: synchronous clear of the sticky flags.
REQ-011 SHALL have port done, output, 1 bit: upper/lower outputs valid this cycle.
REQ-012 SHALL have ports upper_re and upper_im, output, DATA_WIDTH each: X+WY.
REQ-013 SHALL have ports lower_re and lower_im, output, DATA_WIDTH each: X-WY.
REQ-014 SHALL have port overflow, output, 1 bit: sticky saturation flag.
REQ-015 SHALL have port align_error, output, 1 bit: sticky flag for prod_valid/X mismatch.

Function
REQ-016 SHALL delay {x_re, x_im, scale, enable} through a MULT_LATENCY-deep shift register, advancing every cycle.
REQ-017 Stage 1 (register) SHALL form wy_re=ac-bd and wy_im=ad+bc at DATA_WIDTH+1 bits, with no truncation.
REQ-018 Stage 1 SHALL capture the delayed X/scale when prod_valid=1 and the delay-line tail valid=1.
REQ-019 Stage 2 (register) SHALL compute X±WY at DATA_WIDTH+2 bits, with X sign-extended.
REQ-020 When scale=1, stage 2 SHALL arithmetic-shift each sum right by 1 (floor) before saturation.
REQ-021 Stage 2 SHALL saturate each result to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-022 done SHALL be 1 exactly 2 cycles after a cycle with prod_valid=1 and tail valid=1, for one cycle per such cycle.
REQ-023 Back-to-back enables SHALL give back-to-back done pulses, with no bubbles.
REQ-024 Outputs SHALL hold their last value when done=0.
REQ-025 overflow SHALL set in the cycle after any of the four results saturates, and stay set until clear_flags or reset.
REQ-026 align_error SHALL set if prod_valid differs from tail valid in any cycle; that cycle SHALL produce no done.
REQ-027 If clear_flags and a new set event coincide, the set SHALL win.

Reset
REQ-028 On reset=1, all outputs, the delay line and the stage registers SHALL go to 0 immediately, without waiting for clk.
REQ-029 Operations in flight at reset SHALL be discarded; the first done after release SHALL come from a post-reset enable.

Structure
REQ-030 Package fft_pkg SHALL hold DATA_WIDTH, FRAC_BITS=5, the Q11.5 MAX/MIN constants and a complex-sample struct typedef.
REQ-031 Add/sub/shift/saturate SHALL be one combinational sub-module, fft_sat_add_sub, instantiated four times.

Verification
REQ-032 X=(64,0), ac=32, bd=ad=bc=0, scale=0 -> upper=(96,0), lower=(32,0), done 2 cycles after prod_valid.
REQ-033 X=(32000,-32000), ac=1000, bc=1000, others 0 -> upper=(32767,-31000), lower=(31000,-32768), overflow=1 next cycle, held until clear_flags.
REQ-034 scale=1, X=(65,-65), all products 0 -> upper=lower=(32,-33).
REQ-035 Three consecutive enables with distinct X -> three consecutive done pulses with matching results, in order.
REQ-036 prod_valid pulsed with no prior enable -> align_error=1, no done.
REQ-037 reset asserted between enable and done -> outputs 0 asynchronously, no done after release.
